// File: rtl/sipo_pkg.sv
// Shared types and helpers for the serial-in / parallel-out capture register.
package sipo_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HOLD    = 2'd2
    } sipo_state_t;

    // Counter width able to represent 0..bits inclusive.
    function automatic int cnt_w(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/reg_paralelo_carga_serie_en_if.sv
// Capture-side bus: serial strobe/data in, parallel word out on a valid/ready pair.
// valid/ready: a word transfers on any clk edge where valid=1 and ready=1; DP is stable while valid=1.
interface reg_paralelo_carga_serie_en_if
    import sipo_pkg::*;
#(
    parameter int BITS = 8
);
    logic                     start;
    logic                     EN;
    logic                     D;
    logic                     ready;
    logic [BITS-1:0]          DP;
    logic                     valid;
    logic                     busy;
    logic [cnt_w(BITS)-1:0]   count;
    logic                     overrun;
    sipo_state_t              state;

    modport master (
        output start, EN, D, ready,
        input  DP, valid, busy, count, overrun, state
    );

    modport slave (
        input  start, EN, D, ready,
        output DP, valid, busy, count, overrun, state
    );
endinterface

// File: rtl/sipo_bit_counter.sv
// Bit counter for the capture register: sync clear, enable, terminal flag on the last bit.
module sipo_bit_counter
    import sipo_pkg::*;
#(
    parameter int BITS = 8,
    parameter int CW   = cnt_w(BITS)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    output logic [CW-1:0] count_o,
    output logic          term_o
);
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i) begin
            count_d = count_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign term_o  = en_i && (count_q == CW'(BITS - 1));
endmodule

// File: rtl/reg_paralelo_carga_serie_en.sv
// SIPO capture register: assembles BITS serial bits into a word and offers it on valid/ready.
// Define SIPO_MSB_FIRST_EN for MSB-first capture (left shift) instead of the default LSB-first.
module reg_paralelo_carga_serie_en
    import sipo_pkg::*;
#(
    parameter int BITS = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    reg_paralelo_carga_serie_en_if.slave  bus
);
    localparam int CW = cnt_w(BITS);

    sipo_state_t     state_q, state_d;
    logic [BITS-1:0] dp_q, dp_d;
    logic            overrun_q, overrun_d;
    logic            cnt_clr, cnt_en, cnt_term;
    logic [CW-1:0]   cnt;
    logic [BITS-1:0] dp_shifted;

`ifdef SIPO_MSB_FIRST_EN
    assign dp_shifted = {dp_q[BITS-2:0], bus.D};
`else
    assign dp_shifted = {bus.D, dp_q[BITS-1:1]};
`endif

    sipo_bit_counter #(.BITS(BITS), .CW(CW)) u_cnt (
        .clk     (clk),
        .rst     (rst),
        .clr_i   (cnt_clr),
        .en_i    (cnt_en),
        .count_o (cnt),
        .term_o  (cnt_term)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dp_q      <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dp_q      <= dp_d;
            overrun_q <= overrun_d;
        end
    end

    // start outranks EN in COLLECT; in HOLD it only counts alongside a completed handshake.
    always_comb begin
        state_d   = state_q;
        dp_d      = dp_q;
        overrun_d = overrun_q;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = COLLECT;
                    cnt_clr = 1'b1;
                end
            end
            COLLECT: begin
                if (bus.start) begin
                    cnt_clr = 1'b1;
                end else if (bus.EN) begin
                    cnt_en = 1'b1;
                    dp_d   = dp_shifted;
                    if (cnt_term) begin
                        state_d = HOLD;
                    end
                end
            end
            HOLD: begin
                if (bus.EN) begin
                    overrun_d = 1'b1;
                end
                if (bus.ready) begin
                    if (bus.start) begin
                        state_d = COLLECT;
                        cnt_clr = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (cnt_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_comb begin
        bus.DP      = dp_q;
        bus.valid   = (state_q == HOLD);
        bus.busy    = (state_q == COLLECT);
        bus.count   = cnt;
        bus.overrun = overrun_q;
        bus.state   = state_q;
    end
endmodule

// File: tb/tb_reg_paralelo_carga_serie_en.sv
// Directed bench for the SIPO capture register with an expected-word scoreboard.
module tb_reg_paralelo_carga_serie_en;
    import sipo_pkg::*;

    localparam int BITS = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    reg_paralelo_carga_serie_en_if #(.BITS(BITS)) bus ();

    reg_paralelo_carga_serie_en #(.BITS(BITS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    logic [BITS-1:0] exp_q[$];
    logic valid_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: each new word presented on valid is compared with the oldest expected word.
    always @(negedge clk) begin
        if (bus.valid === 1'b1 && valid_prev !== 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_word", 32'(bus.DP), 32'hDEAD);
            end else begin
                check("word", 32'(bus.DP), 32'(exp_q.pop_front()));
            end
        end
        valid_prev = bus.valid;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic d);
        bus.EN = 1'b1;
        bus.D  = d;
        tick();
        bus.EN = 1'b0;
        bus.D  = 1'b0;
    endtask

    // Sends w so that it lands unchanged in DP for the configured shift direction.
    task automatic send_word(input logic [BITS-1:0] w);
        for (int i = 0; i < BITS; i++) begin
`ifdef SIPO_MSB_FIRST_EN
            send_bit(w[BITS-1-i]);
`else
            send_bit(w[i]);
`endif
        end
    endtask

    task automatic do_start();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
    endtask

    logic [BITS-1:0] held;

    initial begin
        bus.start = 1'b0;
        bus.EN    = 1'b0;
        bus.D     = 1'b0;
        bus.ready = 1'b0;
        tick();
        tick();
        check("rst_dp",      32'(bus.DP), 32'h0);
        check("rst_count",   32'(bus.count), 32'd0);
        check("rst_valid",   32'(bus.valid), 32'd0);
        check("rst_busy",    32'(bus.busy), 32'd0);
        check("rst_overrun", 32'(bus.overrun), 32'd0);
        check("rst_state",   32'(bus.state), 32'(IDLE));
        rst = 1'b0;
        tick();

        // EN ignored in IDLE
        send_bit(1'b1);
        check("idle_en_count", 32'(bus.count), 32'd0);

        // LSB-first capture of 1,0,1,0,0,1,0,1 -> A5 in either direction
        do_start();
        check("start_busy", 32'(bus.busy), 32'd1);
        exp_q.push_back(8'hA5);
        send_bit(1); send_bit(0); send_bit(1); send_bit(0);
        send_bit(0); send_bit(1); send_bit(0);
        check("pre_last_valid", 32'(bus.valid), 32'd0);
        send_bit(1);
        check("lat_valid", 32'(bus.valid), 32'd1);
        check("lat_count", 32'(bus.count), 32'd8);
        check("lat_busy",  32'(bus.busy), 32'd0);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        check("hs_valid", 32'(bus.valid), 32'd0);
        check("hs_state", 32'(bus.state), 32'(IDLE));

        // Gapped strobes for 3C
        do_start();
        exp_q.push_back(8'h3C);
        begin
            logic [BITS-1:0] w;
            w = 8'h3C;
            for (int i = 0; i < BITS; i++) begin
`ifdef SIPO_MSB_FIRST_EN
                send_bit(w[BITS-1-i]);
`else
                send_bit(w[i]);
`endif
                check("gap_count_en", 32'(bus.count), 32'(i + 1));
                if (i < BITS - 1) begin
                    tick();
                    check("gap_count_idle", 32'(bus.count), 32'(i + 1));
                    check("gap_busy", 32'(bus.busy), 32'd1);
                end
            end
        end
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;

        // Backpressure and overrun
        do_start();
        exp_q.push_back(8'h5A);
        send_word(8'h5A);
        held = bus.DP;
        bus.EN = 1'b1;
        bus.D  = 1'b0;
        tick();
        bus.EN = 1'b0;
        bus.start = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        bus.start = 1'b0;
        check("bp_dp",      32'(bus.DP), 32'h5A);
        check("bp_held",    32'(bus.DP), 32'(held));
        check("bp_valid",   32'(bus.valid), 32'd1);
        check("bp_overrun", 32'(bus.overrun), 32'd1);
        check("bp_count",   32'(bus.count), 32'd8);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        check("bp_hs_valid",   32'(bus.valid), 32'd0);
        check("bp_hs_overrun", 32'(bus.overrun), 32'd1);
        do_start();
        check("ovr_clear", 32'(bus.overrun), 32'd0);

        // Abort: 4 bits, then start with EN, then FF
        send_bit(0); send_bit(0); send_bit(1); send_bit(0);
        check("abort_pre_count", 32'(bus.count), 32'd4);
        bus.start = 1'b1;
        bus.EN    = 1'b1;
        bus.D     = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.EN    = 1'b0;
        check("abort_count", 32'(bus.count), 32'd0);
        check("abort_busy",  32'(bus.busy), 32'd1);
        exp_q.push_back(8'hFF);
        send_word(8'hFF);

        // Back-to-back: ready and start together in HOLD
        bus.ready = 1'b1;
        bus.start = 1'b1;
        tick();
        bus.ready = 1'b0;
        bus.start = 1'b0;
        check("b2b_state", 32'(bus.state), 32'(COLLECT));
        check("b2b_count", 32'(bus.count), 32'd0);
        check("b2b_valid", 32'(bus.valid), 32'd0);
        exp_q.push_back(8'h81);
        send_word(8'h81);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;

        // Reset mid-capture
        do_start();
        send_bit(1); send_bit(1); send_bit(1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_dp",    32'(bus.DP), 32'h0);
        check("mrst_count", 32'(bus.count), 32'd0);
        check("mrst_valid", 32'(bus.valid), 32'd0);
        check("mrst_busy",  32'(bus.busy), 32'd0);
        check("mrst_state", 32'(bus.state), 32'(IDLE));

        // Raw order 1,0,0,0,0,0,0,0: first bit lands at the capture end
        do_start();
`ifdef SIPO_MSB_FIRST_EN
        exp_q.push_back(8'h80);
`else
        exp_q.push_back(8'h01);
`endif
        send_bit(1);
        for (int i = 0; i < BITS - 1; i++) send_bit(0);
        bus.ready = 1'b1;
        tick();
        bus.ready = 1'b0;
        tick();
        tick();

        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
